// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, default geometry and beat/lane helpers for the load/store unit.
//   lsu_state_t  - FSM state encoding (IDLE, ACCESS, DONE)
//   beat_count() - number of bus beats needed for an access
//   lane_mask()  - byte lanes touched by an access on a given beat
package lsu_pkg;

  localparam int unsigned LSU_BUS_BYTES = 2;
  localparam int unsigned LSU_MAX_BYTES = 4;
  localparam int unsigned LSU_ADDR_W    = 20;
  localparam int unsigned OFF_W         = $clog2(LSU_BUS_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  // Beats spanned by bytes off .. off+size-1 of a bus-aligned window.
  function automatic int unsigned beat_count(input int unsigned off,
                                             input int unsigned size,
                                             input int unsigned bus_bytes);
    return (off + size + bus_bytes - 1) / bus_bytes;
  endfunction

  // Lanes of beat 'beat' that carry access bytes; bus widths up to 8 bytes.
  function automatic logic [7:0] lane_mask(input int unsigned off,
                                           input int unsigned size,
                                           input int unsigned beat,
                                           input int unsigned bus_bytes);
    logic [7:0]  mask;
    int unsigned pos;
    mask = '0;
    for (int unsigned l = 0; l < 8; l++) begin
      pos = beat * bus_bytes + l;
      if (l < bus_bytes && pos >= off && pos < off + size) mask[l[2:0]] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering between MDR byte order and bus lanes.
//   off/size/beat - access geometry and current beat index
//   mdr           - store data in access byte order
//   rd_data       - bus read data for the current beat
//   bytesel       - active lanes on this beat
//   wr_data       - store data placed on its lanes, other lanes 0
//   merge_en      - MDR bytes filled by this beat on a load
//   merge_data    - read bytes moved into MDR byte positions
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 2,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned OFF_BITS  = 1,
  parameter int unsigned SIZE_W    = 3,
  parameter int unsigned BEAT_W    = 2
) (
  input  logic [OFF_BITS-1:0]    off,
  input  logic [SIZE_W-1:0]      size,
  input  logic [BEAT_W-1:0]      beat,
  input  logic [8*MAX_BYTES-1:0] mdr,
  input  logic [8*BUS_BYTES-1:0] rd_data,
  output logic [BUS_BYTES-1:0]   bytesel,
  output logic [8*BUS_BYTES-1:0] wr_data,
  output logic [MAX_BYTES-1:0]   merge_en,
  output logic [8*MAX_BYTES-1:0] merge_data
);

  // Access byte j lives at window position off+j; it is on this beat when that
  // position falls in [beat*BUS_BYTES, beat*BUS_BYTES + BUS_BYTES).
  always_comb begin
    bytesel    = BUS_BYTES'(lane_mask(32'(off), 32'(size), 32'(beat), BUS_BYTES));
    wr_data    = '0;
    merge_en   = '0;
    merge_data = '0;
    for (int unsigned j = 0; j < MAX_BYTES; j++) begin
      for (int unsigned l = 0; l < BUS_BYTES; l++) begin
        if (j < 32'(size) && 32'(off) + j == 32'(beat) * BUS_BYTES + l) begin
          wr_data[8*l +: 8]    = mdr[8*j +: 8];
          merge_en[j]          = 1'b1;
          merge_data[8*j +: 8] = rd_data[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns one segment:offset access of 1..MAX_BYTES bytes into
// one or more BUS_BYTES-wide bus beats, splitting and reassembling as needed.
//   write_mar/mar_in, write_mdr/mdr_in - register loads (blocked while busy)
//   segment                            - segment base, stable during an access
//   start/size/wr_en                   - access request, sampled in IDLE
//   busy/complete                      - status; complete pulses once per access
//   mdr_out                            - MDR contents (load result)
//   m_*                                - memory arbiter beat interface
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_BYTES = LSU_BUS_BYTES,
  parameter int unsigned MAX_BYTES = LSU_MAX_BYTES,
  parameter int unsigned ADDR_W    = LSU_ADDR_W
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  write_mar,
  input  logic [15:0]                           segment,
  input  logic [15:0]                           mar_in,
  input  logic                                  write_mdr,
  input  logic [8*MAX_BYTES-1:0]                mdr_in,
  output logic [8*MAX_BYTES-1:0]                mdr_out,
  output logic [ADDR_W-$clog2(BUS_BYTES)-1:0]   m_addr,
  input  logic [8*BUS_BYTES-1:0]                m_data_in,
  output logic [8*BUS_BYTES-1:0]                m_data_out,
  output logic                                  m_access,
  input  logic                                  m_ack,
  output logic                                  m_wr_en,
  output logic [BUS_BYTES-1:0]                  m_bytesel,
  input  logic                                  start,
  input  logic [$clog2(MAX_BYTES):0]            size,
  input  logic                                  wr_en,
  output logic                                  busy,
  output logic                                  complete
);

  localparam int unsigned OFF_BITS  = $clog2(BUS_BYTES);
  localparam int unsigned SIZE_W    = $clog2(MAX_BYTES) + 1;
  localparam int unsigned MADDR_W   = ADDR_W - OFF_BITS;
  localparam int unsigned MAX_BEATS = (2 * BUS_BYTES - 2 + MAX_BYTES) / BUS_BYTES;
  localparam int unsigned BEAT_W    = $clog2(MAX_BEATS) + 1;

  lsu_state_t             state, state_next;
  logic [15:0]            mar;
  logic [8*MAX_BYTES-1:0] mdr;
  logic [ADDR_W-1:0]      phys, phys_q;
  logic [SIZE_W-1:0]      size_q;
  logic                   wr_q;
  logic [BEAT_W-1:0]      beat_q;
  logic                   size_ok;
  logic                   last_beat;
  logic                   in_access;

  logic [BUS_BYTES-1:0]   lane_sel;
  logic [8*BUS_BYTES-1:0] lane_wr_data;
  logic [MAX_BYTES-1:0]   merge_en;
  logic [8*MAX_BYTES-1:0] merge_data;

  // Linear physical address; the sum wraps at 2^ADDR_W.
  assign phys      = ADDR_W'(32'({segment, 4'b0000}) + 32'(mar));
  assign size_ok   = (size != '0) && (32'(size) <= MAX_BYTES);
  assign last_beat = (32'(beat_q) + 32'd1) ==
                     beat_count(32'(phys_q[OFF_BITS-1:0]), 32'(size_q), BUS_BYTES);
  assign in_access = (state == ACCESS);
  assign mdr_out   = mdr;

  lsu_lane_align #(
    .BUS_BYTES (BUS_BYTES),
    .MAX_BYTES (MAX_BYTES),
    .OFF_BITS  (OFF_BITS),
    .SIZE_W    (SIZE_W),
    .BEAT_W    (BEAT_W)
  ) u_lane_align (
    .off        (phys_q[OFF_BITS-1:0]),
    .size       (size_q),
    .beat       (beat_q),
    .mdr        (mdr),
    .rd_data    (m_data_in),
    .bytesel    (lane_sel),
    .wr_data    (lane_wr_data),
    .merge_en   (merge_en),
    .merge_data (merge_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = size_ok ? ACCESS : DONE;
      ACCESS:  if (m_ack && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and the latched request.
  always_comb begin
    m_access   = 1'b0;
    busy       = 1'b0;
    complete   = 1'b0;
    m_wr_en    = 1'b0;
    m_bytesel  = '0;
    m_data_out = '0;
    m_addr     = phys_q[ADDR_W-1:OFF_BITS] + MADDR_W'(beat_q);
    case (state)
      ACCESS: begin
        m_access   = 1'b1;
        busy       = 1'b1;
        m_wr_en    = wr_q;
        m_bytesel  = lane_sel;
        m_data_out = wr_q ? lane_wr_data : '0;
      end
      DONE:    complete = 1'b1;
      default: ;
    endcase
  end

  // Request latch, beat counter, MAR and MDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar    <= '0;
      mdr    <= '0;
      phys_q <= '0;
      size_q <= '0;
      wr_q   <= 1'b0;
      beat_q <= '0;
    end else begin
      if (write_mar && !in_access) mar <= mar_in;

      if (state == IDLE && start && size_ok) begin
        phys_q <= phys;
        size_q <= size;
        wr_q   <= wr_en;
        beat_q <= '0;
      end else if (in_access && m_ack) begin
        beat_q <= beat_q + BEAT_W'(1);
      end

      // A load start clears MDR so bytes beyond size read back as 0.
      if (state == IDLE && start && size_ok && !wr_en) begin
        mdr <= '0;
      end else if (write_mdr && !in_access) begin
        mdr <= mdr_in;
      end else if (in_access && m_ack && !wr_q) begin
        for (int unsigned j = 0; j < MAX_BYTES; j++) begin
          if (merge_en[j]) mdr[8*j +: 8] <= merge_data[8*j +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench for load_store_unit with
// BUS_BYTES=2, MAX_BYTES=4, ADDR_W=20 and a sparse word memory behind the bus.
module tb_load_store_unit;

  localparam int unsigned BB = 2;
  localparam int unsigned MB = 4;
  localparam int unsigned AW = 20;
  localparam int unsigned MW = AW - 1;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          write_mar;
  logic [15:0]   segment;
  logic [15:0]   mar_in;
  logic          write_mdr;
  logic [31:0]   mdr_in;
  logic [31:0]   mdr_out;
  logic [MW-1:0] m_addr;
  logic [15:0]   m_data_in;
  logic [15:0]   m_data_out;
  logic          m_access;
  logic          m_ack;
  logic          m_wr_en;
  logic [1:0]    m_bytesel;
  logic          start;
  logic [SW-1:0] size;
  logic          wr_en;
  logic          busy;
  logic          complete;

  load_store_unit #(.BUS_BYTES(BB), .MAX_BYTES(MB), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_mar  (write_mar),
    .segment    (segment),
    .mar_in     (mar_in),
    .write_mdr  (write_mdr),
    .mdr_in     (mdr_in),
    .mdr_out    (mdr_out),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .m_access   (m_access),
    .m_ack      (m_ack),
    .m_wr_en    (m_wr_en),
    .m_bytesel  (m_bytesel),
    .start      (start),
    .size       (size),
    .wr_en      (wr_en),
    .busy       (busy),
    .complete   (complete)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [logic [MW-1:0]];
  logic [15:0] model_mar;
  logic [31:0] model_mdr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem_rd(input logic [MW-1:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  // One complete access: optional register loads, then every beat is compared
  // against a byte-by-byte model of where each access byte lands on the bus.
  task automatic do_access(input logic [15:0] seg, input logic [15:0] mar, input bit load_mar,
                           input int size_v, input bit wr, input logic [31:0] mdr_v,
                           input bit load_mdr, input bit inject);
    int unsigned   phys, off, base, nb, p, k, l, t, d;
    logic [MW-1:0] e_addr [4];
    logic [1:0]    e_sel  [4];
    logic [15:0]   e_dat  [4];
    logic [31:0]   e_mdr;
    logic [15:0]   w;

    segment = seg;
    if (load_mar || load_mdr) begin
      write_mar = load_mar;
      mar_in    = mar;
      write_mdr = load_mdr;
      mdr_in    = mdr_v;
      tick();
      write_mar = 1'b0;
      write_mdr = 1'b0;
      if (load_mar) model_mar = mar;
      if (load_mdr) model_mdr = mdr_v;
    end

    phys  = (32'(seg) * 16 + 32'(model_mar)) % (32'd1 << AW);
    off   = phys % BB;
    base  = phys / BB;
    nb    = (off + 32'(size_v) + BB - 1) / BB;
    e_mdr = '0;
    for (int i = 0; i < 4; i++) begin
      e_addr[i] = MW'(base + 32'(i));
      e_sel[i]  = '0;
      e_dat[i]  = '0;
    end
    for (int j = 0; j < size_v; j++) begin
      p = off + 32'(j);
      k = p / BB;
      l = p % BB;
      e_sel[k][l] = 1'b1;
      if (wr) e_dat[k][8*l +: 8] = model_mdr[8*j +: 8];
      else begin
        w = mem_rd(e_addr[k]);
        e_mdr[8*j +: 8] = w[8*l +: 8];
      end
    end

    start = 1'b1;
    size  = SW'(size_v);
    wr_en = wr;
    tick();
    start = 1'b0;

    for (int unsigned b = 0; b < nb; b++) begin
      t = 0;
      while (!m_access && t < 8) begin
        tick();
        t++;
      end
      check($sformatf("beat%0d_access", b), 64'(m_access), 64'(1));
      check($sformatf("beat%0d_busy", b),   64'(busy),     64'(1));
      check($sformatf("beat%0d_addr", b),   64'(m_addr),   64'(e_addr[b]));
      check($sformatf("beat%0d_sel", b),    64'(m_bytesel), 64'(e_sel[b]));
      check($sformatf("beat%0d_wren", b),   64'(m_wr_en),  64'(wr));
      if (wr) check($sformatf("beat%0d_data", b), 64'(m_data_out), 64'(e_dat[b]));

      if (inject && b == 0) begin
        start     = 1'b1;
        size      = SW'(1);
        wr_en     = ~wr;
        write_mar = 1'b1;
        mar_in    = ~mar;
        write_mdr = 1'b1;
        mdr_in    = ~model_mdr;
        tick();
        start     = 1'b0;
        write_mar = 1'b0;
        write_mdr = 1'b0;
        check("inject_addr", 64'(m_addr), 64'(e_addr[b]));
        check("inject_wren", 64'(m_wr_en), 64'(wr));
      end

      d = $urandom_range(0, 2);
      repeat (d) tick();
      m_ack     = 1'b1;
      m_data_in = wr ? 16'($urandom) : mem_rd(e_addr[b]);
      tick();
      m_ack     = 1'b0;
      m_data_in = 16'($urandom);
    end

    check("done_complete", 64'(complete), 64'(1));
    check("done_busy",     64'(busy),     64'(0));
    check("done_access",   64'(m_access), 64'(0));
    tick();
    check("idle_complete", 64'(complete), 64'(0));
    if (!wr) model_mdr = e_mdr;
    check("mdr_after", 64'(mdr_out), 64'(model_mdr));
  endtask

  // A start whose size is out of range must complete without touching the bus.
  task automatic bad_size(input int size_v);
    start = 1'b1;
    size  = SW'(size_v);
    wr_en = 1'b0;
    tick();
    start = 1'b0;
    check("badsz_complete", 64'(complete), 64'(1));
    check("badsz_access",   64'(m_access), 64'(0));
    check("badsz_busy",     64'(busy),     64'(0));
    tick();
    check("badsz_complete2", 64'(complete), 64'(0));
    check("badsz_access2",   64'(m_access), 64'(0));
    check("badsz_mdr",       64'(mdr_out),  64'(model_mdr));
  endtask

  initial begin
    reset = 1'b1; write_mar = 1'b0; write_mdr = 1'b0; segment = '0; mar_in = '0;
    mdr_in = '0; m_data_in = '0; m_ack = 1'b0; start = 1'b0; size = '0; wr_en = 1'b0;
    model_mar = '0;
    model_mdr = '0;
    #1;
    check("rst_access",   64'(m_access),  64'(0));
    check("rst_busy",     64'(busy),      64'(0));
    check("rst_complete", 64'(complete),  64'(0));
    check("rst_wren",     64'(m_wr_en),   64'(0));
    check("rst_sel",      64'(m_bytesel), 64'(0));
    check("rst_mdr",      64'(mdr_out),   64'(0));
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Aligned 16-bit load.
    mem[MW'(32'h08002)] = 16'hBEEF;
    do_access(16'h1000, 16'h0004, 1'b1, 2, 1'b0, 32'h0, 1'b0, 1'b0);
    check("tp_aligned_mdr", 64'(mdr_out), 64'h0000BEEF);

    // Odd 16-bit load split across two words.
    mem[MW'(32'h08002)] = 16'h34AA;
    mem[MW'(32'h08003)] = 16'h5512;
    do_access(16'h1000, 16'h0005, 1'b1, 2, 1'b0, 32'h0, 1'b0, 1'b0);
    check("tp_split_mdr", 64'(mdr_out), 64'h00001234);

    // Three-beat 32-bit store.
    do_access(16'h1000, 16'h0003, 1'b1, 4, 1'b1, 32'hAABBCCDD, 1'b1, 1'b0);

    // Linear wrap at the top of the address space.
    do_access(16'hFFFF, 16'h000F, 1'b1, 2, 1'b0, 32'h0, 1'b0, 1'b0);

    // Held inputs pulsed mid-access, then MAR/MDR reused without reloading.
    do_access(16'h1000, 16'h0003, 1'b1, 4, 1'b1, 32'h11223344, 1'b1, 1'b1);
    do_access(16'h1000, 16'h0000, 1'b0, 4, 1'b1, 32'h0, 1'b0, 1'b0);
    do_access(16'h2000, 16'h0007, 1'b1, 2, 1'b0, 32'h0, 1'b0, 1'b1);
    do_access(16'h2000, 16'h0000, 1'b0, 3, 1'b1, 32'h0, 1'b0, 1'b0);

    bad_size(0);
    bad_size(5);

    // Ack outside ACCESS is ignored.
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    check("stray_ack_complete", 64'(complete), 64'(0));
    check("stray_ack_busy",     64'(busy),     64'(0));

    // Reset during beat 2 of a split load.
    segment = 16'h1000; write_mar = 1'b1; mar_in = 16'h0005;
    tick();
    write_mar = 1'b0;
    start = 1'b1; size = SW'(2); wr_en = 1'b0;
    tick();
    start = 1'b0;
    m_ack = 1'b1; m_data_in = 16'h7788;
    tick();
    m_ack = 1'b0;
    check("prerst_access", 64'(m_access), 64'(1));
    reset = 1'b1;
    #1;
    check("midrst_access",   64'(m_access), 64'(0));
    check("midrst_busy",     64'(busy),     64'(0));
    check("midrst_mdr",      64'(mdr_out),  64'(0));
    check("midrst_complete", 64'(complete), 64'(0));
    tick();
    reset = 1'b0;
    model_mar = '0;
    model_mdr = '0;
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_ack_complete", 64'(complete), 64'(0));
      check("late_ack_busy",     64'(busy),     64'(0));
      tick();
    end

    // Random accesses.
    for (int i = 0; i < 40; i++) begin
      do_access(16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0),
                int'($urandom_range(1, MB)), 1'($urandom), 32'($urandom),
                1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised successor of the CPU's single-access load/store path.
- Converts one segment:offset access of 1..MAX_BYTES bytes into one or more bus beats on a BUS_BYTES-wide memory bus.
- Splits and reassembles unaligned or lane-crossing accesses.
- Sits between the microcode MAR/MDR datapath and the memory arbiter.

Parameters:
- BUS_BYTES, 2, memory bus width in bytes; power of two, 2..8.
- MAX_BYTES, 4, largest single access in bytes; power of two, at least 1.
- ADDR_W, 20, physical byte-address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- write_mar  in  1  load MAR from mar_in
- segment  in  16  segment base, held stable during an access
- mar_in  in  16  offset to load into MAR
- write_mdr  in  1  load MDR from mdr_in
- mdr_in  in  8*MAX_BYTES  store data
- mdr_out  out  8*MAX_BYTES  MDR contents; load result, zero-extended
- m_addr  out  ADDR_W-log2(BUS_BYTES)  bus word address
- m_data_in  in  8*BUS_BYTES  read data
- m_data_out  out  8*BUS_BYTES  write data, lane-aligned
- m_access  out  1  beat request
- m_ack  in  1  beat done, one-cycle pulse
- m_wr_en  out  1  beat is a write
- m_bytesel  out  BUS_BYTES  active byte lanes
- start  in  1  begin access
- size  in  log2(MAX_BYTES)+1  access length in bytes, 1..MAX_BYTES
- wr_en  in  1  1 = store, 0 = load; sampled at start
- busy  out  1  access in progress
- complete  out  1  one-cycle pulse after the final beat

Behaviour:
- Reset (asynchronous):
  - state returns to IDLE; MAR and MDR clear to 0.
  - m_access, complete, busy and m_wr_en go to 0; m_bytesel goes to 0.
  - An in-flight beat is abandoned; a late m_ack is ignored.
- Address calculation:
  - phys = ({segment,4'b0} + MAR) mod 2^ADDR_W. Linear wrap: 0xFFFF0+0x0020 gives 0x00010.
  - off = phys mod BUS_BYTES.
  - base = phys >> log2(BUS_BYTES).
  - nbeats = ceil((off + size) / BUS_BYTES), range 1..ceil((BUS_BYTES-1+MAX_BYTES)/BUS_BYTES).
  - Beat k: m_addr = (base + k) mod 2^(ADDR_W-log2 BUS_BYTES).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - start with size in 1..MAX_BYTES latches phys, size, wr_en and clears the beat counter.
  - For a load, MDR clears to 0 on the same edge.
  - Next state is ACCESS.
  - size = 0 or size > MAX_BYTES goes straight to DONE with no bus beat.
- ACCESS:
  - m_access = 1 and busy = 1.
  - Each m_ack advances the beat counter on that edge.
  - The ack on the last beat moves the FSM to DONE.
  - m_access stays high between beats; each ack retires exactly one beat.
- DONE:
  - complete = 1 for exactly one cycle; busy = 0 in this cycle.
  - Next state is IDLE. A start here is honoured on the next cycle.
- Byte lanes for access byte j (0..size-1): beat = (off+j)/BUS_BYTES, lane = (off+j) mod BUS_BYTES.
  - m_bytesel on beat k sets exactly the lanes holding access bytes.
  - Example, BUS_BYTES=2: aligned 16-bit access gives 11; odd 8-bit gives 10; odd 16-bit gives 10 then 01.
- Loads:
  - On each ack, lanes selected in that beat are written to MDR byte j.
  - MDR bytes j >= size stay 0.
- Stores:
  - m_data_out lane = MDR byte j for selected lanes.
  - Unselected lanes drive 0.
  - m_wr_en = latched wr_en while in ACCESS, else 0.
- Held inputs:
  - start is ignored when not in IDLE.
  - write_mar and write_mdr are ignored while busy; MAR and MDR are protected.
  - write_mdr and a load ack cannot coincide, because write_mdr is blocked while busy.
- m_ack outside ACCESS is ignored.
- Back-to-back accesses have a minimum 2-cycle gap: DONE, then IDLE sampling start.

Decomposition:
- Package lsu_pkg:
  - lsu_state_t enum {IDLE, ACCESS, DONE}.
  - functions beat_count(off,size) and lane_mask(off,size,beat).
  - localparam OFF_W = log2(BUS_BYTES).
- Sub-module lsu_lane_align, combinational:
  - Inputs: off, size, beat index, MDR.
  - Outputs: m_bytesel, m_data_out and the per-byte load-merge enables.
- Top level keeps the FSM, beat counter, MAR, MDR and latched request.

Test Plan:
- BUS_BYTES=2, segment=0x1000, MAR=0x0004, size=2 load, bus returns 0xBEEF -> one beat, m_addr=0x08002, bytesel 11; complete one cycle after ack; mdr_out=0x0000BEEF.
- MAR=0x0005, size=2 load, beats return 0x34xx then 0xxx12 -> m_addr 0x08002 then 0x08003, bytesel 10 then 01; mdr_out=0x00001234.
- MAR=0x0003, size=4 store, MDR=0xAABBCCDD -> beats at 0x08001, 0x08002, 0x08003:
  - beat 1: bytesel 10, data 0xDD00
  - beat 2: bytesel 11, data 0xBBCC
  - beat 3: bytesel 01, data 0x00AA
  - m_wr_en=1 on all three beats.
- segment=0xFFFF, MAR=0x000F, size=2 load -> beat 1 addr 0x7FFFF bytesel 10; beat 2 wraps to addr 0x00000 bytesel 01.
- Assert reset during beat 2 of a split load -> m_access=0, busy=0, mdr_out=0 immediately; a subsequent m_ack pulse produces no complete.
- start, write_mar and write_mdr pulsed mid-access -> ignored; MAR and MDR unchanged, beat sequence unchanged; size=0 start -> complete after 1 cycle with no m_access.
